// File: rtl/flash_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// flash_arbiter_pkg
// Shared types and constants for the two-port SPI flash read arbiter.
//   state_t      : sequencer states (IDLE, SETUP, SHIFT, HOLD, GAP)
//   READ_CMD     : standard single-IO read opcode sent before the address
//   *_BITS       : frame layout of one read transaction on the flash pins
//   byte_swap32  : reorders the MSB-first received stream into a
//                  little-endian word (flash byte k -> bits [8k+7:8k])
// -----------------------------------------------------------------------------
package flash_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] READ_CMD   = 8'h03;
  localparam int         CMD_BITS   = 8;
  localparam int         ADDR_BITS  = 24;
  localparam int         DATA_BITS  = 32;
  localparam int         TOTAL_BITS = 64;

  // The shift-in register holds flash byte 0 in its top byte; the requester
  // wants flash byte 0 in the bottom byte.
  function automatic logic [DATA_BITS-1:0] byte_swap32(input logic [DATA_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_arbiter_shifter.sv
// -----------------------------------------------------------------------------
// flash_arbiter_shifter
// SPI bit engine for one mode-0 read frame: 8 command + 24 address bits out
// on io0, then 32 data bits in on io1.
//   clk, resetn     : system clock, async active-low reset
//   i_load          : grant strobe; latches {READ_CMD, i_addr}, restarts the
//                     divider and slot counter, presents command bit 7
//   i_addr          : word-aligned byte address to transmit
//   i_shift_en      : high while the sequencer is in SHIFT
//   i_io1           : MISO from the flash
//   o_tick          : divider terminal count (one clk every CLKDIV clks)
//   o_done          : falling edge that ends the last slot
//   o_sclk          : flash_clk
//   o_io0_oe/o_io0_do : MOSI enable and data
//   o_rx            : received data in stream order (byte 0 in [31:24])
// -----------------------------------------------------------------------------
module flash_arbiter_shifter
  import flash_arbiter_pkg::*;
#(
  parameter int CLKDIV = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_load,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic                 i_shift_en,
  input  logic                 i_io1,
  output logic                 o_tick,
  output logic                 o_done,
  output logic                 o_sclk,
  output logic                 o_io0_oe,
  output logic                 o_io0_do,
  output logic [DATA_BITS-1:0] o_rx
);

  localparam int                TX_BITS        = CMD_BITS + ADDR_BITS;
  localparam int                SLOT_W         = $clog2(TOTAL_BITS);
  localparam logic [SLOT_W-1:0] LAST_SLOT      = SLOT_W'(TOTAL_BITS - 1);
  localparam logic [SLOT_W-1:0] FIRST_DATA     = SLOT_W'(TX_BITS);
  localparam logic [SLOT_W-1:0] LAST_ADDR_SLOT = SLOT_W'(TX_BITS - 1);
  localparam logic [7:0]        DIV_RELOAD     = 8'(CLKDIV - 1);

  logic [7:0]           r_div;
  logic [SLOT_W-1:0]    r_slot;
  logic [TX_BITS-1:0]   r_tx;
  logic [DATA_BITS-1:0] r_rx;
  logic                 r_sclk;
  logic                 r_oe;
  logic                 r_do;

  logic w_tick;
  logic w_rise;
  logic w_fall;

  assign w_tick = (r_div == 8'd0);
  assign w_rise = i_shift_en & w_tick & ~r_sclk;
  assign w_fall = i_shift_en & w_tick &  r_sclk;

  assign o_tick   = w_tick;
  assign o_done   = w_fall & (r_slot == LAST_SLOT);
  assign o_sclk   = r_sclk;
  assign o_io0_oe = r_oe;
  assign o_io0_do = r_do;
  assign o_rx     = r_rx;

  // Free-running down-counter; reloading it at the grant aligns every later
  // phase (SETUP, each half slot, HOLD, GAP) to CLKDIV-cycle boundaries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
    end else if (i_load || w_tick) begin
      r_div <= DIV_RELOAD;
    end else begin
      r_div <= r_div - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_sclk <= 1'b0;
      r_oe   <= 1'b0;
      r_do   <= 1'b0;
    end else if (i_load) begin
      r_slot <= '0;
      r_sclk <= 1'b0;
      r_tx   <= {READ_CMD, i_addr};
      r_oe   <= 1'b1;
      r_do   <= READ_CMD[7];
    end else if (w_rise) begin
      r_sclk <= 1'b1;
      if (r_slot >= FIRST_DATA) begin
        r_rx <= {r_rx[DATA_BITS-2:0], i_io1};
      end
    end else if (w_fall) begin
      r_sclk <= 1'b0;
      if (r_slot != LAST_SLOT) begin
        r_slot <= r_slot + SLOT_W'(1);
        // Zeros shift in behind the address, so io0_do idles low once the
        // data phase starts.
        r_tx   <= {r_tx[TX_BITS-2:0], 1'b0};
        r_do   <= r_tx[TX_BITS-2];
        if (r_slot == LAST_ADDR_SLOT) begin
          r_oe <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// -----------------------------------------------------------------------------
// flash_arbiter
// Two-port round-robin read arbiter and sequencer for a single-IO SPI flash.
// Each granted request runs one 0x03 read of a 32-bit word and returns it
// little-endian on that port's rdata with a one-cycle ready pulse.
//   clk, resetn                 : system clock, async active-low reset
//   reqN_valid / reqN_addr      : request and byte address (bits [1:0] ignored)
//   reqN_ready / reqN_rdata     : completion pulse and held read data
//   busy                        : grant through end of GAP
//   flash_csb, flash_clk        : chip select (active low), mode-0 SPI clock
//   flash_io0_oe, flash_io0_do  : MOSI drive
//   flash_io1_di                : MISO
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a valid; grant, latch address, drop csb
// SETUP | CLKDIV cycles of csb low with command bit 7 on io0 before clocking
// SHIFT | 64 slots: command + address out, then data in
// HOLD  | CLKDIV cycles with clock low before releasing csb
// GAP   | CLKDIV cycles of csb high, then back to IDLE
// -----------------------------------------------------------------------------
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int CLKDIV = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req0_valid,
  input  logic [ADDR_BITS-1:0] req0_addr,
  output logic                 req0_ready,
  output logic [DATA_BITS-1:0] req0_rdata,
  input  logic                 req1_valid,
  input  logic [ADDR_BITS-1:0] req1_addr,
  output logic                 req1_ready,
  output logic [DATA_BITS-1:0] req1_rdata,
  output logic                 busy,
  output logic                 flash_csb,
  output logic                 flash_clk,
  output logic                 flash_io0_oe,
  output logic                 flash_io0_do,
  input  logic                 flash_io1_di
);

  state_t               r_state;
  logic                 r_last_grant;
  logic                 r_grant;
  logic                 r_csb;
  logic                 r_busy;
  logic                 r_ready0;
  logic                 r_ready1;
  logic [DATA_BITS-1:0] r_rdata0;
  logic [DATA_BITS-1:0] r_rdata1;

  logic                 w_any;
  logic                 w_pick1;
  logic                 w_load;
  logic [ADDR_BITS-1:0] w_addr;
  logic                 w_tick;
  logic                 w_done;
  logic [DATA_BITS-1:0] w_rx;

  assign w_any   = req0_valid | req1_valid;
  // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
  assign w_pick1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_load  = (r_state == ST_IDLE) & w_any;
  assign w_addr  = (w_pick1 ? req1_addr : req0_addr) & 24'hFF_FFFC;

  flash_arbiter_shifter #(
    .CLKDIV (CLKDIV)
  ) u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_load),
    .i_addr     (w_addr),
    .i_shift_en (r_state == ST_SHIFT),
    .i_io1      (flash_io1_di),
    .o_tick     (w_tick),
    .o_done     (w_done),
    .o_sclk     (flash_clk),
    .o_io0_oe   (flash_io0_oe),
    .o_io0_do   (flash_io0_do),
    .o_rx       (w_rx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_csb        <= 1'b1;
      r_busy       <= 1'b0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant      <= w_pick1;
            r_last_grant <= w_pick1;
            r_csb        <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_done) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_csb   <= 1'b1;
            r_state <= ST_GAP;
            // The transaction completes even if its valid was dropped early.
            if (r_grant) begin
              r_ready1 <= 1'b1;
              r_rdata1 <= byte_swap32(w_rx);
            end else begin
              r_ready0 <= 1'b1;
              r_rdata0 <= byte_swap32(w_rx);
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = r_ready0;
  assign req1_ready = r_ready1;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;
  assign busy       = r_busy;
  assign flash_csb  = r_csb;

endmodule

// File: tb/tb_flash_arbiter.sv
module tb_flash_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        resetn;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic        sel3;
  logic        flash_io1_di;

  logic        rdy0_1, rdy1_1, busy_1, csb_1, sclk_1, oe_1, do_1;
  logic [31:0] rd0_1, rd1_1;
  logic        rdy0_3, rdy1_3, busy_3, csb_3, sclk_3, oe_3, do_3;
  logic [31:0] rd0_3, rd1_3;

  logic        m_rdy0, m_rdy1, m_busy, m_csb, m_sclk, m_oe, m_do;
  logic [31:0] m_rdata0, m_rdata1;

  assign m_rdy0   = sel3 ? rdy0_3 : rdy0_1;
  assign m_rdy1   = sel3 ? rdy1_3 : rdy1_1;
  assign m_busy   = sel3 ? busy_3 : busy_1;
  assign m_csb    = sel3 ? csb_3  : csb_1;
  assign m_sclk   = sel3 ? sclk_3 : sclk_1;
  assign m_oe     = sel3 ? oe_3   : oe_1;
  assign m_do     = sel3 ? do_3   : do_1;
  assign m_rdata0 = sel3 ? rd0_3  : rd0_1;
  assign m_rdata1 = sel3 ? rd1_3  : rd1_1;

  flash_arbiter #(.CLKDIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid & ~sel3), .req0_addr(req0_addr), .req0_ready(rdy0_1), .req0_rdata(rd0_1),
    .req1_valid(req1_valid & ~sel3), .req1_addr(req1_addr), .req1_ready(rdy1_1), .req1_rdata(rd1_1),
    .busy(busy_1), .flash_csb(csb_1), .flash_clk(sclk_1),
    .flash_io0_oe(oe_1), .flash_io0_do(do_1), .flash_io1_di(flash_io1_di)
  );

  flash_arbiter #(.CLKDIV(3)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid & sel3), .req0_addr(req0_addr), .req0_ready(rdy0_3), .req0_rdata(rd0_3),
    .req1_valid(req1_valid & sel3), .req1_addr(req1_addr), .req1_ready(rdy1_3), .req1_rdata(rd1_3),
    .busy(busy_3), .flash_csb(csb_3), .flash_clk(sclk_3),
    .flash_io0_oe(oe_3), .flash_io0_do(do_3), .flash_io1_di(flash_io1_di)
  );

  // ---------------- flash device model (1 KiB, aliased) ----------------
  logic [7:0]  mem [0:1023];
  int          fl_bits = 0, fl_rises = 0, fl_oe_err = 0;
  int          hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0, csb_low = 0;
  logic [31:0] fl_sh = '0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  time         t_edge = 0, t_csb = 0;

  always @(negedge m_csb) begin
    fl_bits = 0; fl_rises = 0; fl_oe_err = 0;
    hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
    t_csb = $time; t_edge = $time;
  end

  always @(posedge m_csb) csb_low = int'(($time - t_csb) / 10);

  always @(posedge m_sclk) begin
    int lo;
    if (!m_csb) begin
      if (fl_rises > 0) begin
        lo = int'(($time - t_edge) / 10);
        if (lo < lo_min) lo_min = lo;
        if (lo > lo_max) lo_max = lo;
      end
      t_edge = $time;
      if (m_oe !== 1'(fl_bits < 32)) fl_oe_err++;
      if (fl_bits < 32) fl_sh = {fl_sh[30:0], m_do};
      fl_bits++;
      fl_rises++;
      if (fl_bits == 32) begin
        fl_cmd  = fl_sh[31:24];
        fl_addr = fl_sh[23:0];
      end
    end
  end

  always @(negedge m_sclk) begin
    int hi, k;
    logic [7:0] b;
    if (!m_csb) begin
      hi = int'(($time - t_edge) / 10);
      if (hi < hi_min) hi_min = hi;
      if (hi > hi_max) hi_max = hi;
      t_edge = $time;
      if (fl_bits >= 32 && fl_bits < 64) begin
        k = fl_bits - 32;
        b = mem[(int'(fl_addr) + k / 8) % 1024];
        flash_io1_di = b[7 - (k % 8)];
      end
    end
  end

  // ---------------- reference model and bookkeeping ----------------
  int          n_cmp = 0, n_mis = 0;
  int          tb_d = 1;
  bit          model_last = 1'b1;
  bit          busy_prev = 1'b0;
  logic [31:0] exp_rd [2];
  logic [23:0] q0[$], q1[$];
  int          exp_port_q[$], exp_gcyc_q[$];
  logic [23:0] exp_addr_q[$];
  int          act_port_q[$], grant_q[$], done_cyc_q[$];

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    int base;
    base = int'(a) & 32'h3FC;
    return {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic completion();
    int p, g;
    logic [23:0] a;
    chk("ready_exclusive", {63'd0, m_rdy0 & m_rdy1}, 64'd0);
    if (exp_port_q.size() == 0) begin
      chk("unexpected_ready", 64'd0, 64'd1);
      return;
    end
    p = exp_port_q.pop_front();
    a = exp_addr_q.pop_front();
    g = exp_gcyc_q.pop_front();
    act_port_q.push_back(m_rdy1 ? 1 : 0);
    done_cyc_q.push_back(cyc);
    exp_rd[p] = ref_word(a);
    chk("ready_port", m_rdy1 ? 1 : 0, p);
    chk("rdata0", m_rdata0, exp_rd[0]);
    chk("rdata1", m_rdata1, exp_rd[1]);
    chk("ready_latency", cyc - g, 130 * tb_d);
    chk("sclk_rises", fl_rises, 64);
    chk("cmd_sent", fl_cmd, 8'h03);
    chk("addr_sent", fl_addr, a & 24'hFFFFFC);
    chk("sclk_high_len", {hi_min, hi_max}, {tb_d, tb_d});
    chk("sclk_low_len", {lo_min, lo_max}, {tb_d, tb_d});
    chk("io0_oe_phase", fl_oe_err, 0);
    chk("csb_low_len", csb_low, 130 * tb_d);
  endtask

  task automatic service(input int n, input int budget);
    int got, k, p;
    got = 0;
    k = 0;
    while (got < n && k < budget) begin
      @(negedge clk);
      k++;
      if (m_busy && !busy_prev) begin
        p = (req1_valid && (!req0_valid || !model_last)) ? 1 : 0;
        model_last = p[0];
        exp_port_q.push_back(p);
        exp_addr_q.push_back(p == 1 ? req1_addr : req0_addr);
        exp_gcyc_q.push_back(cyc);
        grant_q.push_back(cyc);
      end
      busy_prev = m_busy;
      if (m_rdy0 || m_rdy1) begin
        completion();
        got++;
      end
      if (m_rdy0) req0_valid = 1'b0;
      if (m_rdy1) req1_valid = 1'b0;
      if (!req0_valid && q0.size() > 0) begin req0_valid = 1'b1; req0_addr = q0.pop_front(); end
      if (!req1_valid && q1.size() > 0) begin req1_valid = 1'b1; req1_addr = q1.pop_front(); end
    end
    chk("service_done_count", got, n);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    busy_prev = 1'b0;
    exp_port_q.delete(); exp_addr_q.delete(); exp_gcyc_q.delete();
    resetn = 1'b1;
  endtask

  initial begin
    int g, r, w, nreq;
    bit saw_ready;
    logic [1:0] m;

    resetn = 1'b0; sel3 = 1'b0; flash_io1_di = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
    mem[32] = 8'h55; mem[33] = 8'h66; mem[34] = 8'h77; mem[35] = 8'h88;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_csb", m_csb, 1);
    chk("rst_sclk", m_sclk, 0);
    chk("rst_oe", m_oe, 0);
    chk("rst_do", m_do, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_ready", {m_rdy0, m_rdy1}, 0);
    chk("rst_rdata", {m_rdata0, m_rdata1}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_grant", m_busy, 0);

    // single read on port 0
    q0.push_back(24'h000010);
    service(1, 400);
    chk("single_rdata0", m_rdata0, 32'h44332211);

    // tie after reset: port 0 first, then port 1
    apply_reset();
    act_port_q.delete();
    q0.push_back(24'h000010);
    q1.push_back(24'h000020);
    service(2, 600);
    if (act_port_q.size() == 2) begin
      chk("tie_first_port", act_port_q[0], 0);
      chk("tie_second_port", act_port_q[1], 1);
    end
    chk("tie_rdata0_kept", m_rdata0, 32'h44332211);
    chk("tie_rdata1", m_rdata1, 32'h88776655);

    // continuous contention: alternate grants 132 cycles apart
    act_port_q.delete();
    grant_q.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(24'($urandom));
      q1.push_back(24'($urandom));
    end
    service(6, 1200);
    chk("contend_count", act_port_q.size(), 6);
    if (act_port_q.size() == 6 && grant_q.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("contend_port", act_port_q[i], i % 2);
      for (int i = 1; i < 6; i++) chk("contend_spacing", grant_q[i] - grant_q[i - 1], 132);
    end

    // randomized request patterns
    for (int rnd = 0; rnd < 5; rnd++) begin
      m = 2'($urandom_range(1, 3));
      nreq = 0;
      if (m[0]) begin q0.push_back(24'($urandom)); nreq++; end
      if (m[1]) begin q1.push_back(24'($urandom)); nreq++; end
      if ($urandom_range(0, 1) == 1) begin q0.push_back(24'($urandom)); nreq++; end
      service(nreq, nreq * 140 + 50);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    // unaligned address
    q1.push_back(24'h000013);
    service(1, 400);
    chk("unaligned_rdata1", m_rdata1, 32'h44332211);
    chk("unaligned_addr_tx", fl_addr, 24'h000010);

    // reset during SHIFT with valid held
    req0_addr = 24'h000020;
    req0_valid = 1'b1;
    w = 0;
    while (!m_busy && w < 10) begin @(negedge clk); w++; end
    chk("rst_test_grant_seen", m_busy, 1);
    g = cyc;
    saw_ready = 1'b0;
    while (cyc < g + 50) begin
      @(negedge clk);
      if (m_rdy0 || m_rdy1) saw_ready = 1'b1;
    end
    #2;
    chk("pre_reset_csb", m_csb, 0);
    chk("pre_reset_sclk", m_sclk, 1);
    resetn = 1'b0;
    #1;
    chk("async_csb", m_csb, 1);
    chk("async_sclk", m_sclk, 0);
    chk("async_oe", m_oe, 0);
    chk("async_busy", m_busy, 0);
    chk("async_rdata_cleared", {m_rdata0, m_rdata1}, 0);
    repeat (2) @(negedge clk);
    if (m_rdy0 || m_rdy1) saw_ready = 1'b1;
    chk("no_ready_on_reset", saw_ready, 0);
    model_last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    busy_prev = 1'b0;
    exp_port_q.delete(); exp_addr_q.delete(); exp_gcyc_q.delete();
    grant_q.delete();
    done_cyc_q.delete();
    r = cyc;
    resetn = 1'b1;
    service(1, 400);
    if (grant_q.size() == 1 && done_cyc_q.size() == 1) begin
      chk("regrant_after_release", grant_q[0] - r, 1);
      chk("ready_after_release", done_cyc_q[0] - r, 131);
    end
    chk("reset_read_rdata0", m_rdata0, 32'h88776655);

    // CLKDIV = 3 instance
    sel3 = 1'b1;
    tb_d = 3;
    apply_reset();
    q0.push_back(24'h000010);
    service(1, 600);
    chk("div3_rdata0", m_rdata0, 32'h44332211);
    chk("div3_addr_tx", fl_addr, 24'h000010);
    q0.push_back(24'($urandom));
    q1.push_back(24'($urandom));
    service(2, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Two-port read arbiter and sequencer for the board's single-IO SPI flash. It accepts 32-bit word read requests from two independent requesters, grants them round-robin, and runs each as a standard SPI read (command 0x03, 24-bit address, 32 data bits) on the shared flash pins. It sits between the SoC-side requesters (e.g. boot loader/DMA and a configuration fetch port) and the flash_csb/flash_clk/io pads.

## Interface
- CLKDIV, 1: flash_clk half-period in clk cycles; legal range 1..255.
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 read request.
- req0_addr  in  24  port 0 byte address; word aligned, bits [1:0] ignored and sent as 0.
- req0_ready  out  1  one-cycle completion pulse for port 0.
- req0_rdata  out  32  port 0 read data.
- req1_valid, req1_addr, req1_ready, req1_rdata: same as port 0, for port 1.
- busy  out  1  high from grant until the end of the GAP state.
- flash_csb  out  1  chip select, active low.
- flash_clk  out  1  SPI clock, mode 0.
- flash_io0_oe  out  1  output enable for io0 (MOSI).
- flash_io0_do  out  1  io0 output data.
- flash_io1_di  in  1  io1 input (MISO).

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if any valid is high, grant a port, latch {addr[23:2], 2'b00}, go to SETUP, and drive csb low.
- Arbitration is round-robin on a last_grant bit. On a tie, the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
- SETUP: lasts CLKDIV cycles with csb=0, flash_clk=0, io0_oe=1 and io0_do = cmd bit 7.
- SHIFT: 64 bit slots, 8 command + 24 address out on io0 followed by 32 data in on io1.
  - Each slot is CLKDIV cycles with flash_clk low, then CLKDIV cycles with flash_clk high.
  - io0_do changes only when flash_clk goes 1->0 (and on SETUP entry). Bits are sent MSB first.
  - io0_oe drops to 0 at the falling edge that starts data slot 0.
  - io1 is registered on the clk edge that drives flash_clk 0->1.
- Data assembly is byte-wise little-endian: flash byte k maps to rdata[8k+7:8k], and bits within each byte are MSB first.
- HOLD: lasts CLKDIV cycles with flash_clk=0 and csb=0.
- Leaving HOLD:
  - csb goes to 1.
  - The granted port's reqN_ready pulses high for one cycle.
  - reqN_rdata updates.
  - The state moves to GAP.
- GAP: lasts CLKDIV cycles with csb=1, then returns to IDLE.
- reqN_rdata holds its value until the next completion on that port. The other port's rdata is never disturbed.
- Requester rules:
  - valid and addr must stay stable until ready.
  - A valid dropped early is a protocol violation. The granted transaction still completes and pulses ready.
- Reset values: csb=1, flash_clk=0, io0_oe=0, io0_do=0, ready=0, rdata=0, busy=0, state=IDLE, last_grant=1.
- Reset mid-operation:
  - Pins return to reset values immediately (asynchronous) and the transaction is dropped with no ready pulse.
  - A valid still held after release is re-granted from IDLE.

## Timing
- The grant edge is t=0. The SETUP→SHIFT edge is at t=CLKDIV, and SHIFT→HOLD is at t=129·CLKDIV.
- reqN_ready is high in the cycle after the edge at t=130·CLKDIV. With CLKDIV=1, that is the 131st cycle after the grant.
- The next grant comes no earlier than the edge at t=131·CLKDIV+1.
- csb low time is exactly 130·CLKDIV cycles. Minimum csb high time between transactions is CLKDIV+1 cycles.
- There are exactly 64 flash_clk rising edges per transaction.
- Throughput: one word per 131·CLKDIV+1 cycles under continuous load. Ports alternate when both are held high.

## Structure
- Package flash_arbiter_pkg holds:
  - the state enum,
  - READ_CMD=8'h03,
  - CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32, TOTAL_BITS=64.
- Sub-module flash_arbiter_shifter is the SPI bit engine: divider counter, slot counter, io0 shift-out, io1 shift-in, and done strobe.
- The top level keeps the arbiter, the FSM and the per-port rdata registers.

## Test plan
- Single read: flash bytes 0x000010..13 = 11 22 33 44; port 0 reads addr 0x000010 → req0_rdata=0x44332211, ready at t=130, 64 flash_clk rises.
- Tie: both valid in the same cycle after reset, port0 addr 0x10, port1 addr 0x20 (bytes 55 66 77 88) → port 0 served first, then port 1 gets 0x88776655, and req0_rdata is unchanged.
- Continuous contention: both valid held for 6 transactions → grants alternate 0,1,0,1,0,1 and grant edges are 132 cycles apart (CLKDIV=1).
- CLKDIV=3: read addr 0x000010 → same data, ready at t=390, flash_clk high/low phases exactly 3 cycles each, io0 sequence 0x03,0x000010.
- Reset at t=50 mid-SHIFT → csb=1 and flash_clk=0 asynchronously, no ready; with valid held, the read completes correctly 131 cycles after release plus one grant cycle.
- Unaligned addr 0x000013 → transmitted address 0x000010 and rdata=0x44332211.
